// File: rtl/jtag_pkg.sv
// Shared opcodes, FSM state type and small decode helpers for the JTAG command engine.
package jtag_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] CMD_RESET               = 3'd0;
  localparam logic [OP_W-1:0] CMD_TMS_SEQ             = 3'd1;
  localparam logic [OP_W-1:0] CMD_SCAN_CHAIN          = 3'd2;
  localparam logic [OP_W-1:0] CMD_SCAN_CHAIN_FLIP_TMS = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RST_SEQ = 3'd1,
    ST_FETCH   = 3'd2,
    ST_LOW     = 3'd3,
    ST_HIGH    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  function automatic logic is_known_op(input logic [OP_W-1:0] op);
    return (op == CMD_RESET) || (op == CMD_TMS_SEQ) ||
           (op == CMD_SCAN_CHAIN) || (op == CMD_SCAN_CHAIN_FLIP_TMS);
  endfunction

  function automatic logic is_scan_op(input logic [OP_W-1:0] op);
    return (op == CMD_SCAN_CHAIN) || (op == CMD_SCAN_CHAIN_FLIP_TMS);
  endfunction

  // Returns {tms, tdi} for one data bit of a TMS sequence or scan.
  function automatic logic [1:0] pin_bits(input logic [OP_W-1:0] op, input logic b,
                                          input logic last);
    if (op == CMD_TMS_SEQ) return {b, 1'b0};
    return {(op == CMD_SCAN_CHAIN_FLIP_TMS) && last, b};
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK phase timer: counts TCK_DIV clk cycles per half period and flags the
// cycle whose closing edge raises (rise_en) or lowers (fall_en) TCK.
module jtag_tck_gen #(
  parameter int unsigned TCK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic rise_en,
  output logic fall_en
);

  localparam int unsigned CNT_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TCK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             phase_q;
  logic             wrap;

  assign wrap    = en && (cnt_q == CNT_MAX);
  assign rise_en = wrap && !phase_q;
  assign fall_en = wrap && phase_q;

  // Disabled means parked at the start of a low half period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (!en) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (wrap) begin
      cnt_q   <= '0;
      phase_q <= !phase_q;
    end else begin
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/jtag_cmd_engine.sv
// JTAG master: executes reset / TMS-sequence / scan commands from a valid-ready
// port, streaming TMS/TDI beats in and captured TDO beats out.
module jtag_cmd_engine
  import jtag_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned TCK_DIV    = 4,
  parameter int unsigned RESET_CLKS = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_nbits,
  output logic              cmd_err,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [DATA_W-1:0] din_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_last,
  output logic              busy,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [2:0]        op_q;
  logic [LEN_W-1:0]  nbits_q;
  logic [LEN_W-1:0]  bit_cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] sreg_q, sreg_nx;
  logic [DATA_W-1:0] asm_q, cap_vec;
  logic              din_got_q, din_got_d;

  logic gen_en, rise_en, fall_en;
  logic acc, din_fire, dout_ok, fetch_go;
  logic last_bit, next_last, beat_end, rst_last;

  logic              tck_d, tms_d, tdi_d, din_ready_d, cmd_err_d;
  logic              dout_valid_d, dout_last_d;
  logic [DATA_W-1:0] dout_data_d;

  assign gen_en = (state_q == ST_RST_SEQ) || (state_q == ST_LOW) || (state_q == ST_HIGH);

  jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (gen_en),
    .rise_en (rise_en),
    .fall_en (fall_en)
  );

  assign acc       = cmd_valid && cmd_ready;
  assign din_fire  = din_valid && din_ready;
  assign dout_ok   = !is_scan_op(op_q) || !dout_valid || dout_ready;
  assign fetch_go  = (state_q == ST_FETCH) && (din_got_q || din_fire) && dout_ok;
  assign last_bit  = (bit_cnt_q == (nbits_q - LEN_W'(1)));
  assign next_last = ((bit_cnt_q + LEN_W'(1)) == (nbits_q - LEN_W'(1)));
  assign beat_end  = (idx_q == IDX_LAST);
  assign rst_last  = (bit_cnt_q == LEN_W'(RESET_CLKS));
  assign sreg_nx   = sreg_q >> 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (acc) begin
          if (cmd_op == CMD_RESET)      state_d = ST_RST_SEQ;
          else if (!is_known_op(cmd_op)) state_d = ST_IDLE;
          else if (cmd_nbits == '0)      state_d = ST_DONE;
          else                           state_d = ST_FETCH;
        end
      end
      ST_RST_SEQ: if (fall_en && rst_last) state_d = ST_DONE;
      ST_FETCH:   if (fetch_go) state_d = ST_LOW;
      ST_LOW:     if (rise_en) state_d = ST_HIGH;
      ST_HIGH: begin
        if (fall_en) begin
          if (last_bit)      state_d = ST_DONE;
          else if (beat_end) state_d = ST_FETCH;
          else               state_d = ST_LOW;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered pins and handshake outputs.
  always_comb begin
    tck_d        = tck;
    tms_d        = tms;
    tdi_d        = tdi;
    din_got_d    = din_got_q;
    dout_valid_d = dout_valid;
    dout_last_d  = dout_last;
    dout_data_d  = dout_data;
    cmd_err_d    = acc && !is_known_op(cmd_op);
    cap_vec      = asm_q;
    cap_vec[idx_q] = tdo;

    if (rise_en) tck_d = 1'b1;
    if (fall_en) tck_d = 1'b0;
    if (dout_valid && dout_ready) dout_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (acc && (cmd_op == CMD_RESET)) begin
          tms_d = (RESET_CLKS != 0);
          tdi_d = 1'b0;
        end
      end
      ST_RST_SEQ: begin
        if (fall_en && !rst_last) tms_d = ((bit_cnt_q + LEN_W'(1)) < LEN_W'(RESET_CLKS));
      end
      ST_FETCH: begin
        if (fetch_go) begin
          {tms_d, tdi_d} = pin_bits(op_q, din_got_q ? sreg_q[0] : din_data[0], last_bit);
          din_got_d      = 1'b0;
        end else if (din_fire) begin
          din_got_d = 1'b1;
        end
      end
      ST_LOW: begin
        // Beat completes on its last bit's rising edge, including that bit's tdo.
        if (rise_en && is_scan_op(op_q) && (beat_end || last_bit)) begin
          dout_valid_d = 1'b1;
          dout_data_d  = cap_vec;
          dout_last_d  = last_bit;
        end
      end
      ST_HIGH: begin
        if (fall_en && !last_bit && !beat_end) {tms_d, tdi_d} = pin_bits(op_q, sreg_nx[0], next_last);
      end
      default: ;
    endcase

    if ((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_FETCH)) tck_d = 1'b0;
    if ((state_d == ST_IDLE) || (state_d == ST_DONE)) begin
      tms_d = 1'b0;
      tdi_d = 1'b0;
    end
    din_ready_d = (state_d == ST_FETCH) && !din_got_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tck        <= 1'b0;
      tms        <= 1'b0;
      tdi        <= 1'b0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      cmd_err    <= 1'b0;
      din_ready  <= 1'b0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      dout_data  <= '0;
    end else begin
      tck        <= tck_d;
      tms        <= tms_d;
      tdi        <= tdi_d;
      cmd_ready  <= (state_d == ST_IDLE);
      busy       <= (state_d != ST_IDLE);
      cmd_err    <= cmd_err_d;
      din_ready  <= din_ready_d;
      dout_valid <= dout_valid_d;
      dout_last  <= dout_last_d;
      dout_data  <= dout_data_d;
    end
  end

  // Command latch, bit/beat counters, din shifter and tdo assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= CMD_RESET;
      nbits_q   <= '0;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      sreg_q    <= '0;
      asm_q     <= '0;
      din_got_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acc) begin
            op_q      <= cmd_op;
            nbits_q   <= cmd_nbits;
            bit_cnt_q <= '0;
            idx_q     <= '0;
          end
        end
        ST_RST_SEQ: if (fall_en) bit_cnt_q <= bit_cnt_q + LEN_W'(1);
        ST_FETCH: begin
          if (din_fire) sreg_q <= din_data;
          if (fetch_go) begin
            asm_q <= '0;
            idx_q <= '0;
          end
        end
        ST_LOW: if (rise_en) asm_q[idx_q] <= tdo;
        ST_HIGH: begin
          if (fall_en) begin
            bit_cnt_q <= bit_cnt_q + LEN_W'(1);
            idx_q     <= idx_q + IDX_W'(1);
            sreg_q    <= sreg_nx;
          end
        end
        default: ;
      endcase
      din_got_q <= din_got_d;
    end
  end

endmodule

// File: tb/tb_jtag_cmd_engine.sv
// Randomized scoreboard bench for jtag_cmd_engine: a queue-based command model
// predicts every TCK-rise pin pair, every dout beat and every cmd_err pulse.
module tb_jtag_cmd_engine;
  import jtag_pkg::*;

  localparam int DATA_W     = 8;
  localparam int LEN_W      = 16;
  localparam int TCK_DIV    = 2;
  localparam int RESET_CLKS = 5;

  logic              clk, rst;
  logic              cmd_valid, cmd_ready, cmd_err;
  logic [2:0]        cmd_op;
  logic [LEN_W-1:0]  cmd_nbits;
  logic              din_valid, din_ready;
  logic [DATA_W-1:0] din_data;
  logic              dout_valid, dout_ready, dout_last;
  logic [DATA_W-1:0] dout_data;
  logic              busy, tck, tms, tdi, tdo;

  jtag_cmd_engine #(.DATA_W(DATA_W), .LEN_W(LEN_W), .TCK_DIV(TCK_DIV),
                    .RESET_CLKS(RESET_CLKS)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_nbits(cmd_nbits), .cmd_err(cmd_err),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_last(dout_last),
    .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  int checks = 0;
  int failures = 0;
  int rise_cnt = 0;
  int exp_err = 0;
  bit throttle = 0;
  bit hold_dout = 0;

  logic [1:0]        exp_pin[$];
  logic [DATA_W:0]   exp_dout[$];
  logic              tdo_q[$];
  logic [DATA_W-1:0] din_q[$];
  logic [DATA_W-1:0] pat_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic bail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout at %0t", name, $time);
    finish_run();
  endtask

  // Reference model: expand a command into expected pin pairs, tdo stimulus and dout beats.
  task automatic push_cmd(input logic [2:0] op, input int n);
    logic [DATA_W-1:0] beat, cap;
    logic b, t;
    beat = '0;
    cap  = '0;
    if (op == CMD_RESET) begin
      for (int i = 0; i <= RESET_CLKS; i++) begin
        exp_pin.push_back({(i < RESET_CLKS) ? 1'b1 : 1'b0, 1'b0});
        tdo_q.push_back(1'($urandom_range(1)));
      end
    end else if (op == CMD_TMS_SEQ || op == CMD_SCAN_CHAIN || op == CMD_SCAN_CHAIN_FLIP_TMS) begin
      for (int i = 0; i < n; i++) begin
        if (i % DATA_W == 0) begin
          if (pat_q.size() > 0) beat = pat_q.pop_front();
          else beat = DATA_W'($urandom);
          din_q.push_back(beat);
          cap = '0;
        end
        b = beat[i % DATA_W];
        t = 1'($urandom_range(1));
        tdo_q.push_back(t);
        if (op == CMD_TMS_SEQ) begin
          exp_pin.push_back({b, 1'b0});
        end else begin
          exp_pin.push_back({(op == CMD_SCAN_CHAIN_FLIP_TMS) && (i == n - 1), b});
          cap[i % DATA_W] = t;
          if ((i % DATA_W == DATA_W - 1) || (i == n - 1)) exp_dout.push_back({(i == n - 1), cap});
        end
      end
    end else begin
      exp_err++;
    end
  endtask

  task automatic issue(input logic [2:0] op, input int n);
    int t;
    t = 0;
    push_cmd(op, n);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_nbits = LEN_W'(n);
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      t++;
      if (t > 5000) bail("cmd_accept");
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 10000) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (!busy && exp_pin.size() == 0 && exp_dout.size() == 0) break;
      t++;
      if (t > 20000) bail("wait_idle");
    end
  endtask

  // din source: serves queued beats, optionally with random gaps.
  initial begin
    bit fire;
    din_valid = 1'b0;
    din_data  = '0;
    forever begin
      @(negedge clk);
      fire = din_valid && din_ready;
      @(posedge clk); #1;
      if (fire && din_q.size() > 0) void'(din_q.pop_front());
      if (din_q.size() > 0 && (!throttle || $urandom_range(3) != 0)) begin
        din_valid = 1'b1;
        din_data  = din_q[0];
      end else begin
        din_valid = 1'b0;
        din_data  = '0;
      end
    end
  end

  initial begin
    dout_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      dout_ready = hold_dout ? 1'b0 : (throttle ? 1'($urandom_range(1)) : 1'b1);
    end
  end

  // Monitor: pops expectations on each TCK rise, dout handshake and cmd_err pulse; drives tdo.
  initial begin
    logic prev_tck;
    logic [1:0] ep;
    logic [DATA_W:0] ed;
    prev_tck = 1'b0;
    tdo = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tck && !prev_tck) begin
          rise_cnt++;
          if (exp_pin.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pin_unexpected tms=%0b tdi=%0b at %0t", tms, tdi, $time);
          end else begin
            ep = exp_pin.pop_front();
            chk("pin_tms_tdi", 64'({tms, tdi}), 64'(ep));
          end
          if (tdo_q.size() > 0) void'(tdo_q.pop_front());
        end
        if (dout_valid && dout_ready) begin
          if (exp_dout.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL dout_unexpected data=%0h last=%0b at %0t", dout_data, dout_last, $time);
          end else begin
            ed = exp_dout.pop_front();
            chk("dout_last_data", 64'({dout_last, dout_data}), 64'(ed));
          end
        end
        if (cmd_err) begin
          if (exp_err == 0) begin
            checks++;
            failures++;
            $display("FAIL cmd_err_unexpected actual=1 expected=0 at %0t", $time);
          end else begin
            exp_err--;
            chk("cmd_err_pulse", 64'(cmd_err), 64'(1));
          end
        end
      end
      prev_tck = tck;
      tdo = (tdo_q.size() > 0) ? tdo_q[0] : 1'b0;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tck"}, 64'(tck), 0);
    chk({tag, "_tms"}, 64'(tms), 0);
    chk({tag, "_tdi"}, 64'(tdi), 0);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 1);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_din_ready"}, 64'(din_ready), 0);
    chk({tag, "_dout_valid"}, 64'(dout_valid), 0);
    chk({tag, "_dout_last"}, 64'(dout_last), 0);
    chk({tag, "_dout_data"}, 64'(dout_data), 0);
    chk({tag, "_cmd_err"}, 64'(cmd_err), 0);
  endtask

  initial begin
    int n, r0, r;
    logic [2:0] op;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_nbits = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // TAP reset: (RESET_CLKS+1) TCK periods plus one DONE cycle.
    issue(CMD_RESET, 0);
    count_busy(n);
    chk("reset_busy_cycles", 64'(n), 64'(2 * TCK_DIV * (RESET_CLKS + 1) + 1));
    wait_idle();
    chk("reset_cmd_ready_back", 64'(cmd_ready), 1);

    pat_q.push_back(8'h1B);
    issue(CMD_TMS_SEQ, 5);
    wait_idle();
    chk("tms_seq_tms_after", 64'(tms), 0);

    // Unstalled 12-bit scan: 2 fetches + 2*TCK_DIV*12 + DONE.
    pat_q.push_back(8'hA5);
    pat_q.push_back(8'h03);
    issue(CMD_SCAN_CHAIN, 12);
    count_busy(n);
    chk("scan12_busy_cycles", 64'(n), 64'(2 + 2 * TCK_DIV * 12 + 1));
    wait_idle();

    issue(CMD_SCAN_CHAIN_FLIP_TMS, 8);
    wait_idle();

    // Back-pressure on dout: TCK must park low after the first beat.
    hold_dout = 1'b1;
    r0 = rise_cnt;
    issue(CMD_SCAN_CHAIN, 16);
    repeat (120) @(posedge clk);
    @(negedge clk);
    chk("stall_tck_low", 64'(tck), 0);
    chk("stall_rises", 64'(rise_cnt - r0), 8);
    chk("stall_dout_valid", 64'(dout_valid), 1);
    hold_dout = 1'b0;
    wait_idle();

    r0 = rise_cnt;
    issue(3'd4, 5);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("badop_no_tck", 64'(rise_cnt - r0), 0);
    chk("badop_busy", 64'(busy), 0);

    throttle = 1'b1;
    for (int c = 0; c < 40; c++) begin
      r = $urandom_range(99);
      if (r < 8)       op = CMD_RESET;
      else if (r < 25) op = CMD_TMS_SEQ;
      else if (r < 55) op = CMD_SCAN_CHAIN;
      else if (r < 88) op = CMD_SCAN_CHAIN_FLIP_TMS;
      else             op = 3'($urandom_range(7, 4));
      n = ($urandom_range(9) == 0) ? 0 : $urandom_range(24, 1);
      issue(op, n);
    end
    wait_idle();
    throttle = 1'b0;
    chk("random_tms_idle", 64'(tms), 0);
    chk("random_tdi_idle", 64'(tdi), 0);

    // Reset in the middle of a scan drops everything immediately.
    issue(CMD_SCAN_CHAIN, 16);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    exp_pin.delete();
    exp_dout.delete();
    tdo_q.delete();
    din_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);

    issue(CMD_SCAN_CHAIN_FLIP_TMS, 11);
    wait_idle();
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("end_pin_queue_empty", 64'(exp_pin.size()), 0);
    chk("end_dout_queue_empty", 64'(exp_dout.size()), 0);
    chk("end_err_outstanding", 64'(exp_err), 0);
    chk("end_cmd_ready", 64'(cmd_ready), 1);
    finish_run();
  end

endmodule
